// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, ALU op codes, instruction fields
// and the decode/EX control bundles.
package isa_pkg;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RS_MSB   = 11;
    localparam int RS_LSB   = 9;
    localparam int RT_MSB   = 8;
    localparam int RT_LSB   = 6;
    localparam int RD_MSB   = 5;
    localparam int RD_LSB   = 3;
    localparam int FUNC_MSB = 2;
    localparam int FUNC_LSB = 0;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_SUBI  = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_LHW   = 4'h7;
    localparam logic [3:0] OP_SHW   = 4'h8;
    localparam logic [3:0] OP_BEQ   = 4'h9;
    localparam logic [3:0] OP_BNE   = 4'hA;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [3:0] ALU_RTYPE = 4'h0;
    localparam logic [3:0] ALU_ADDI  = 4'h1;
    localparam logic [3:0] ALU_ANDI  = 4'h2;
    localparam logic [3:0] ALU_ORI   = 4'h3;
    localparam logic [3:0] ALU_SUBI  = 4'h4;
    localparam logic [3:0] ALU_LHW   = 4'h7;
    localparam logic [3:0] ALU_SHW   = 4'h8;
    localparam logic [3:0] ALU_BEQ   = 4'h9;
    localparam logic [3:0] ALU_BNE   = 4'hA;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RT,
        DST_RD
    } dst_sel_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       beq;
        logic       bne;
        logic       jump;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        ctrl_t      ctrl;
        logic [2:0] func;
        logic [2:0] dst;
        logic       illegal;
    } id_ex_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode decoder: ALU op, datapath controls,
// source-register usage and destination select.
module main_decoder
    import isa_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs,
    output logic       uses_rt,
    output dst_sel_e   dst_sel,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        dst_sel = DST_NONE;
        illegal = 1'b0;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                ctrl.alu_op    = ALU_RTYPE;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                dst_sel        = DST_RD;
            end
            opcode == OP_ADDI: begin
                ctrl.alu_op    = ALU_ADDI;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                dst_sel        = DST_RT;
            end
            opcode == OP_ANDI: begin
                ctrl.alu_op    = ALU_ANDI;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                dst_sel        = DST_RT;
            end
            opcode == OP_ORI: begin
                ctrl.alu_op    = ALU_ORI;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                dst_sel        = DST_RT;
            end
            opcode == OP_SUBI: begin
                ctrl.alu_op    = ALU_SUBI;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                dst_sel        = DST_RT;
            end
            opcode == OP_LHW: begin
                ctrl.alu_op     = ALU_LHW;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                uses_rs         = 1'b1;
                dst_sel         = DST_RT;
            end
            opcode == OP_SHW: begin
                ctrl.alu_op    = ALU_SHW;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            opcode == OP_BEQ: begin
                ctrl.alu_op = ALU_BEQ;
                ctrl.beq    = 1'b1;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            opcode == OP_BNE: begin
                ctrl.alu_op = ALU_BNE;
                ctrl.bne    = 1'b1;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            opcode == OP_JMP: begin
                ctrl.alu_op = ALU_RTYPE;
                ctrl.jump   = 1'b1;
            end
            opcode == OP_NOP: begin
                ctrl = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_control.sv
// ID-stage control: decode, load-use hazard detection and the
// ID/EX control pipeline register.
module id_ex_control
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_func,
    output logic [2:0]  ex_dst,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_beq,
    output logic        ex_bne,
    output logic        ex_jump,
    output logic        ex_illegal
);

    logic [3:0] opcode;
    logic [2:0] rs, rt, rd, func;
    ctrl_t      dec_ctrl;
    logic       uses_rs, uses_rt, illegal;
    dst_sel_e   dst_sel;
    id_ex_t     dec_word, ex_q;

    assign opcode = id_instr[OPC_MSB:OPC_LSB];
    assign rs     = id_instr[RS_MSB:RS_LSB];
    assign rt     = id_instr[RT_MSB:RT_LSB];
    assign rd     = id_instr[RD_MSB:RD_LSB];
    assign func   = id_instr[FUNC_MSB:FUNC_LSB];

    main_decoder u_dec (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .dst_sel (dst_sel),
        .illegal (illegal)
    );

    // Undefined opcodes become a bubble tagged illegal for the trap path.
    always_comb begin
        dec_word       = '0;
        dec_word.valid = 1'b1;
        dec_word.ctrl  = dec_ctrl;
        dec_word.func  = func;
        unique case (dst_sel)
            DST_RT:  dec_word.dst = rt;
            DST_RD:  dec_word.dst = rd;
            default: dec_word.dst = 3'd0;
        endcase
        if (illegal) begin
            dec_word         = '0;
            dec_word.illegal = 1'b1;
        end
    end

    assign hazard_stall = ex_q.valid & ex_q.ctrl.mem_read & id_valid
                        & ((uses_rs & (rs == ex_q.dst))
                        |  (uses_rt & (rt == ex_q.dst)))
                        & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            if (hazard_stall || !id_valid)
                ex_q <= '0;
            else
                ex_q <= dec_word;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_func       = ex_q.func;
    assign ex_dst        = ex_q.dst;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign ex_beq        = ex_q.ctrl.beq;
    assign ex_bne        = ex_q.ctrl.bne;
    assign ex_jump       = ex_q.ctrl.jump;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_control.sv
// Bench for id_ex_control: directed vector table plus randomized
// stream against a rule-level reference model.
module tb_id_ex_control;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [15:0] id_instr;
    logic        hazard_stall, ex_valid;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_func, ex_dst;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_beq, ex_bne, ex_jump, ex_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_control dut (
        .clk           (clk),
        .rst           (rst),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .stall         (stall),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_func       (ex_func),
        .ex_dst        (ex_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_beq        (ex_beq),
        .ex_bne        (ex_bne),
        .ex_jump       (ex_jump),
        .ex_illegal    (ex_illegal)
    );

    // flags: {alu_src, reg_write, mem_read, mem_write, mem_to_reg, beq, bne, jump}
    typedef struct {
        logic [15:0] ins;
        logic        v, st, fl, r;
        logic        hz;
        logic        ev;
        logic [3:0]  op;
        logic [2:0]  fn, dst;
        logic [7:0]  flags;
        logic        ill;
    } vec_t;

    typedef struct {
        logic       legal;
        logic [3:0] op;
        logic [7:0] flags;
        logic       urs, urt;
        int         dkind;
    } dec_t;

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic [2:0] fn, dst;
        logic [7:0] flags;
        logic       ill;
    } mstate_t;

    vec_t    vecs[$];
    mstate_t m;

    function automatic dec_t dec(input logic [3:0] opc);
        dec_t d;
        d = '{legal: 1'b1, op: 4'h0, flags: 8'h00,
              urs: 1'b1, urt: 1'b0, dkind: 0};
        case (opc)
            4'h0: begin d.flags = 8'b0100_0000; d.urt = 1'b1; d.dkind = 2; end
            4'h1, 4'h2, 4'h3, 4'h4: begin
                d.op = opc; d.flags = 8'b1100_0000; d.dkind = 1;
            end
            4'h7: begin d.op = 4'h7; d.flags = 8'b1110_1000; d.dkind = 1; end
            4'h8: begin d.op = 4'h8; d.flags = 8'b1001_0000; d.urt = 1'b1; end
            4'h9: begin d.op = 4'h9; d.flags = 8'b0000_0100; d.urt = 1'b1; end
            4'hA: begin d.op = 4'hA; d.flags = 8'b0000_0010; d.urt = 1'b1; end
            4'h5: begin d.flags = 8'b0000_0001; d.urs = 1'b0; end
            4'hF: d.urs = 1'b0;
            default: begin d.legal = 1'b0; d.urs = 1'b0; end
        endcase
        return d;
    endfunction

    function automatic void chk(input string name, input int i,
                                input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, i, act, exp);
        end
    endfunction

    function automatic void chk_out(input int i, input logic ev,
                                    input logic [3:0] op, input logic [2:0] fn,
                                    input logic [2:0] dst, input logic [7:0] flags,
                                    input logic ill);
        logic [7:0] af;
        af = {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
              ex_mem_to_reg, ex_beq, ex_bne, ex_jump};
        chk("ex_valid", i, 16'(ex_valid), 16'(ev));
        chk("ex_alu_op", i, 16'(ex_alu_op), 16'(op));
        chk("ex_func", i, 16'(ex_func), 16'(fn));
        chk("ex_flags", i, 16'(af), 16'(flags));
        chk("ex_illegal", i, 16'(ex_illegal), 16'(ill));
        if (flags[6] || !ev)
            chk("ex_dst", i, 16'(ex_dst), 16'(dst));
    endfunction

    task automatic drive(input logic [15:0] ins, input logic v,
                         input logic st, input logic fl, input logic r);
        @(negedge clk);
        id_instr = ins;
        id_valid = v;
        stall    = st;
        flush    = fl;
        rst      = r;
        #1;
    endtask

    task automatic add(input logic [15:0] ins, input logic v, input logic st,
                       input logic fl, input logic r, input logic hz,
                       input logic ev, input logic [3:0] op, input logic [2:0] fn,
                       input logic [2:0] dst, input logic [7:0] flags,
                       input logic ill);
        vecs.push_back('{ins, v, st, fl, r, hz, ev, op, fn, dst, flags, ill});
    endtask

    task automatic rstep(input int i, input logic [15:0] ins, input logic v,
                         input logic st, input logic fl, input logic r);
        dec_t       d;
        logic [2:0] rs, rt;
        logic       ehz;
        d   = dec(ins[15:12]);
        rs  = ins[11:9];
        rt  = ins[8:6];
        ehz = m.valid & m.flags[5] & v & !fl
            & ((d.urs & (rs == m.dst)) | (d.urt & (rt == m.dst)));
        drive(ins, v, st, fl, r);
        chk("hazard_stall", i, 16'(hazard_stall), 16'(ehz));
        if (r || fl || (!st && (ehz || !v))) begin
            m = '{1'b0, 4'h0, 3'd0, 3'd0, 8'h00, 1'b0};
        end else if (!st) begin
            if (!d.legal) begin
                m = '{1'b0, 4'h0, 3'd0, 3'd0, 8'h00, 1'b1};
            end else begin
                m.valid = 1'b1;
                m.op    = d.op;
                m.fn    = ins[2:0];
                m.dst   = (d.dkind == 2) ? ins[5:3] : (d.dkind == 1) ? rt : 3'd0;
                m.flags = d.flags;
                m.ill   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk_out(i, m.valid, m.op, m.fn, m.dst, m.flags, m.ill);
    endtask

    initial begin
        // ins, v, st, fl, r | hz, ev, op, fn, dst, flags, ill
        add(16'h0A53, 1, 0, 0, 0, 0, 1, 4'h0, 3, 2, 8'b0100_0000, 0);
        add(16'h1A80, 1, 0, 0, 0, 0, 1, 4'h1, 0, 2, 8'b1100_0000, 0);
        add(16'h7282, 1, 0, 0, 0, 0, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h0443, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h0443, 1, 0, 0, 0, 0, 1, 4'h0, 3, 0, 8'b0100_0000, 0);
        add(16'h7282, 1, 0, 0, 0, 0, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h8680, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h8680, 1, 0, 0, 0, 0, 1, 4'h8, 0, 0, 8'b1001_0000, 0);
        add(16'h7282, 1, 0, 0, 0, 0, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h5480, 1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 8'b0000_0001, 0);
        add(16'h1A80, 1, 0, 0, 0, 0, 1, 4'h1, 0, 2, 8'b1100_0000, 0);
        add(16'h0443, 1, 1, 0, 0, 0, 1, 4'h1, 0, 2, 8'b1100_0000, 0);
        add(16'h0443, 1, 1, 0, 0, 0, 1, 4'h1, 0, 2, 8'b1100_0000, 0);
        add(16'h0443, 1, 1, 0, 0, 0, 1, 4'h1, 0, 2, 8'b1100_0000, 0);
        add(16'h0443, 1, 1, 1, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h6000, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 1);
        add(16'hF000, 1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'hB123, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'hC000, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h1A80, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h7282, 1, 0, 0, 0, 0, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h0443, 1, 1, 0, 0, 1, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h0443, 1, 1, 0, 1, 1, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h0443, 1, 0, 0, 0, 0, 1, 4'h0, 3, 0, 8'b0100_0000, 0);
        add(16'h7282, 1, 0, 0, 0, 0, 1, 4'h7, 2, 2, 8'b1110_1000, 0);
        add(16'h0443, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h7000, 1, 0, 0, 0, 0, 1, 4'h7, 0, 0, 8'b1110_1000, 0);
        add(16'h9000, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 8'b0000_0000, 0);
        add(16'h9000, 1, 0, 0, 0, 0, 1, 4'h9, 0, 0, 8'b0000_0100, 0);

        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out(-1, 0, 4'h0, 3'd0, 3'd0, 8'h00, 0);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset hazard_stall", -1, 16'(hazard_stall), 16'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].r);
            chk("hazard_stall", i, 16'(hazard_stall), 16'(vecs[i].hz));
            @(posedge clk);
            #1;
            chk_out(i, vecs[i].ev, vecs[i].op, vecs[i].fn, vecs[i].dst,
                    vecs[i].flags, vecs[i].ill);
        end

        m = '{1'b0, 4'h0, 3'd0, 3'd0, 8'h00, 1'b0};
        rstep(1000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            logic [15:0] ins;
            logic [3:0]  opc;
            opc = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            ins = {opc, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            rstep(1001 + k, ins,
                  $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_control.md
# id_ex_control

Decode stage control unit with its ID/EX control pipeline register. It decodes the 16-bit instruction opcode into the 4-bit ALU op code and datapath control bits that the EX-stage ALU control consumes, and registers them into EX together with `func` and the destination register. It detects load-use hazards and inserts bubbles, and it honours external stall and flush. It sits between the IF/ID register and the EX-stage ALU control / datapath muxes.

## Interface
- No parameters. The instruction width (16) and field layout are fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_instr` in 16: ID instruction. Fields: `[15:12]` opcode, `[11:9]` rs, `[8:6]` rt, `[5:3]` rd, `[2:0]` func.
- `id_valid` in 1: `id_instr` is real, not a bubble.
- `stall` in 1: external freeze; EX register holds its value.
- `flush` in 1: branch/jump resolved in EX; the ID instruction is killed.
- `hazard_stall` out 1: combinational load-use stall to the PC and IF/ID.
- `ex_valid` out 1: EX slot holds a real instruction.
- `ex_alu_op` out 4: ALU op code to the ALU control.
- `ex_func` out 3: func field to the ALU control.
- `ex_dst` out 3: destination register.
- `ex_alu_src`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_beq`, `ex_bne`, `ex_jump` out 1 each.
- `ex_illegal` out 1: EX slot came from an undefined opcode.

## Operation
- **Opcode decode**, as `opcode -> alu_op`, with the control bits set:
  - 0000 R-type -> 0000; `reg_write`; dst = rd.
  - 0001 addi -> 0001; 0010 andi -> 0010; 0011 ori -> 0011; 0100 subi -> 0100. Each sets `alu_src` and `reg_write`; dst = rt.
  - 0111 lhw -> 0111; `alu_src`, `mem_read`, `mem_to_reg`, `reg_write`; dst = rt.
  - 1000 shw -> 1000; `alu_src`, `mem_write`.
  - 1001 beq -> 1001, `beq`; 1010 bne -> 1010, `bne`.
  - 0101 jmp -> 0000, `jump`.
  - 1111 nop -> all control bits 0. It is still valid.
  - 0110 and 1011–1110 are illegal. They load a bubble with `ex_illegal`=1 and `ex_valid`=0.
- **Source usage**:
  - rs is read by every valid opcode except jmp and nop.
  - rt is read by R-type, shw, beq and bne.
- **Load-use hazard**: `hazard_stall` = `ex_valid & ex_mem_read & id_valid & ((uses_rs & rs==ex_dst) | (uses_rt & rt==ex_dst))`.
  - The comparison includes register 0; no r0 special case.
  - When `flush`=1, `hazard_stall` is forced to 0.
- **Register update priority** (highest first):
  1. `rst`: EX register cleared.
  2. `flush`: bubble loaded.
  3. `stall`: register holds.
  4. `hazard_stall`: bubble loaded.
  5. `!id_valid`: bubble loaded.
  6. Otherwise: decoded values loaded.
- **Bubble**: every output 0, except `ex_illegal` when the bubble came from an illegal opcode under rule 6 only.

## Timing
- **Reset values**: every `ex_*` output is 0. `hazard_stall` is 0 one cycle after reset, because `ex_valid`=0.
- **Latency**: 1 cycle from ID to EX outputs. `hazard_stall` has 0 latency (combinational).
- **Stall behaviour**:
  - A load-use stall lasts exactly 1 cycle. The bubble clears `ex_mem_read`, so the stalled instruction issues the next cycle.
  - If `stall` and `hazard_stall` are both high, the register holds; `hazard_stall` stays high until `stall` drops.
- **Flush**:
  - A flush together with `stall` still loads a bubble; flush wins.
  - A flush in the same cycle as a load-use match loads a bubble and drops `hazard_stall`.
- **Reset mid-stall**: the EX register clears on the next edge regardless of `stall`/`flush`.

## Structure
- Shared package `isa_pkg` holds:
  - the opcode constants (`OP_RTYPE` … `OP_NOP`);
  - the ALU op code constants (0000–1010), also used by the ALU control;
  - the instruction field bit positions.
- Sub-module `main_decoder`: purely combinational opcode -> {alu_op, control bits, uses_rs, uses_rt, dst_sel, illegal}.
- The top level holds the hazard compare and the EX register.

## Test plan
1. Reset, then feed a valid stream:
   - add `0x0A53` (opcode 0000, rs=5, rt=1, rd=2, func=3) -> next cycle `ex_alu_op`=0000, `ex_func`=3, `ex_dst`=2, `ex_reg_write`=1, `ex_valid`=1.
   - addi `0x1A80` -> `ex_alu_op`=0001, `ex_alu_src`=1, `ex_dst`=2.
2. Issue lhw `0x7282` (rt=2), then R-type `0x0443` (rs=2) -> `hazard_stall`=1 for exactly one cycle, a bubble (`ex_valid`=0) in EX, then the R-type appears in EX.
3. Issue lhw (dst=2), then shw with rt=2, rs=3 -> stall. The same lhw followed by jmp -> no stall.
4. Hold `stall`=1 for 3 cycles with a valid addi in EX -> EX outputs unchanged. Assert `flush` together with `stall` -> bubble on the next edge.
5. Illegal opcode 0110 with `id_valid`=1 -> `ex_illegal`=1, `ex_valid`=0, all control bits 0. nop `0xF000` -> `ex_valid`=1, all controls 0.
6. Assert `rst` during a load-use stall -> all outputs 0 on the next edge; `hazard_stall`=0.
